// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared 1024x768@60 timing constants, monitor state and error indices
//
// Purpose: one place for the display generator timing numbers so the generator
// and the frame monitor cannot drift apart, plus the monitor state encoding and
// the bit positions of the sticky error vector.
package vga_timing_pkg;

  // 1024x768@60, 65 MHz pixel clock
  localparam int VGA_H_DISP  = 1024;
  localparam int VGA_H_FRONT = 24;
  localparam int VGA_H_SYNC  = 136;
  localparam int VGA_H_BACK  = 160;
  localparam int VGA_H_TOTAL = 1344;
  localparam int VGA_V_DISP  = 768;
  localparam int VGA_V_SYNC  = 6;
  localparam int VGA_V_BACK  = 29;
  localparam int VGA_V_TOTAL = 806;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } monState_t;

  // oErr bit positions
  localparam int ERR_HPERIOD = 0;
  localparam int ERR_HWIDTH  = 1;
  localparam int ERR_VPERIOD = 2;
  localparam int ERR_VWIDTH  = 3;

endpackage

// File: rtl/vga_sync_meter.sv
// rtl/vga_sync_meter.sv - period / pulse-width meter for one sync signal
//
// Purpose: edge detection and interval counting for one (already registered)
// sync level. Counting advances only on cycles where iEn is high, so the same
// block measures hsync in clocks (iEn = 1) and vsync in lines (iEn = hsync rise).
// Ports:
//   clk_vga, iReset_n  pixel clock, asynchronous active-low reset
//   iSync              registered sync level
//   iEn                count enable
//   oPeriod            enabled events since the previous rise, including this cycle
//   oWidth             enabled events seen while the sync was high
//   oRise, oFall       edge strobes (combinational, same cycle as the new level)
//   oArmed             at least one rise seen since reset, so oPeriod/oWidth mean something
//   oSat               period counter stuck at its maximum
module vga_sync_meter #(
  parameter int W = 12
) (
  input  logic         clk_vga,
  input  logic         iReset_n,
  input  logic         iSync,
  input  logic         iEn,
  output logic [W-1:0] oPeriod,
  output logic [W-1:0] oWidth,
  output logic         oRise,
  output logic         oFall,
  output logic         oArmed,
  output logic         oSat
);

  localparam logic [W-1:0] CNT_MAX = '1;

  logic         syncD;
  logic [W-1:0] perCnt;
  logic [W-1:0] widCnt;

  assign oRise   = iSync & ~syncD;
  assign oFall   = ~iSync & syncD;
  // An event coinciding with the rise closes the old period rather than opening the new one.
  assign oPeriod = perCnt + {{(W-1){1'b0}}, iEn};
  assign oWidth  = widCnt;
  assign oSat    = (perCnt == CNT_MAX);

  always_ff @(posedge clk_vga or negedge iReset_n) begin
    if (!iReset_n) begin
      syncD  <= 1'b0;
      perCnt <= '0;
      widCnt <= '0;
      oArmed <= 1'b0;
    end else begin
      syncD <= iSync;
      if (oRise) begin
        perCnt <= '0;
        widCnt <= {{(W-1){1'b0}}, iEn};
        oArmed <= 1'b1;
      end else begin
        if (iEn && !oSat)
          perCnt <= perCnt + 1'b1;
        if (iSync && iEn && (widCnt != CNT_MAX))
          widCnt <= widCnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_frame_monitor.sv
// rtl/vga_frame_monitor.sv - passive VGA sink: timing check, lock, frame checksum, probe pixel
//
// Purpose: rebuilds pixel position from hsync/vsync, verifies every timing
// interval, tracks lock, and summarises each locked frame.
// Optional feature macro: VGA_MON_CHECKSUM_EN (defined: per-frame pixel sum in
// oChecksum; undefined: no accumulator, oChecksum reads 16'h0000).
// Ports:
//   clk_vga, iReset_n     pixel clock, asynchronous active-low reset
//   iVGA_Hsync/Vsync      active-high syncs from the display generator
//   iVGA_RGB              {R,G,B} 4 bits each
//   iProbeX, iProbeY      pixel coordinate to capture
//   oLocked               timing verified, monitor tracking
//   oErr                  sticky error flags (see vga_timing_pkg indices)
//   oFrameDone            one-cycle strobe per locked vsync rise
//   oFrameCnt             locked frames seen
//   oChecksum             sum of active pixels of the last complete frame
//   oProbeRGB             pixel captured at the probe coordinate
module vga_frame_monitor
  import vga_timing_pkg::*;
#(
  parameter int H_DISP  = VGA_H_DISP,
  parameter int H_FRONT = VGA_H_FRONT,
  parameter int H_SYNC  = VGA_H_SYNC,
  parameter int H_BACK  = VGA_H_BACK,
  parameter int H_TOTAL = VGA_H_TOTAL,
  parameter int V_DISP  = VGA_V_DISP,
  parameter int V_SYNC  = VGA_V_SYNC,
  parameter int V_BACK  = VGA_V_BACK,
  parameter int V_TOTAL = VGA_V_TOTAL
) (
  input  logic        clk_vga,
  input  logic        iReset_n,
  input  logic        iVGA_Hsync,
  input  logic        iVGA_Vsync,
  input  logic [11:0] iVGA_RGB,
  input  logic [10:0] iProbeX,
  input  logic [10:0] iProbeY,
  output logic        oLocked,
  output logic [3:0]  oErr,
  output logic        oFrameDone,
  output logic [15:0] oFrameCnt,
  output logic [15:0] oChecksum,
  output logic [11:0] oProbeRGB
);

  localparam logic [11:0] HTOT     = 12'(H_TOTAL);
  localparam logic [11:0] HSYNCW   = 12'(H_SYNC);
  localparam logic [11:0] HB       = 12'(H_BACK);
  localparam logic [11:0] HEND     = 12'(H_TOTAL - H_SYNC - H_FRONT);
  localparam logic [11:0] HDISP    = 12'(H_DISP);
  localparam logic [10:0] VTOT     = 11'(V_TOTAL);
  localparam logic [10:0] VSYNCW   = 11'(V_SYNC);
  localparam logic [10:0] VB       = 11'(V_BACK);
  localparam logic [10:0] VEND     = 11'(V_BACK + V_DISP);
  localparam logic [10:0] VDISP    = 11'(V_DISP);
  localparam logic [11:0] HC_MAX   = '1;
  localparam logic [10:0] VL_MAX   = '1;

  // input register stage
  logic        rHs, rVs;
  logic [11:0] rRgb;
  logic [10:0] rProbeX, rProbeY;
  // hc/vl update one cycle after the edge they react to, so the pixel is
  // delayed once more to stay aligned with them
  logic [11:0] pixD;
  logic [11:0] hc;
  logic [10:0] vl;

  logic        hRise, hFall, hArmed, hSat;
  logic [11:0] hPeriod, hWidth;
  logic        vRise, vFall, vArmed, vSat;
  logic [10:0] vPeriod, vWidth;

  monState_t   state, nextState;
  logic [3:0]  errNow;
  logic        anyErr, frameUpd, pixValid, probeHit;
  logic [11:0] xPos;
  logic [10:0] yPos;

  always_ff @(posedge clk_vga or negedge iReset_n) begin
    if (!iReset_n) begin
      rHs     <= 1'b0;
      rVs     <= 1'b0;
      rRgb    <= '0;
      rProbeX <= '0;
      rProbeY <= '0;
      pixD    <= '0;
    end else begin
      rHs     <= iVGA_Hsync;
      rVs     <= iVGA_Vsync;
      rRgb    <= iVGA_RGB;
      rProbeX <= iProbeX;
      rProbeY <= iProbeY;
      pixD    <= rRgb;
    end
  end

  vga_sync_meter #(.W(12)) uHMeter (
    .clk_vga (clk_vga), .iReset_n (iReset_n),
    .iSync   (rHs),     .iEn      (1'b1),
    .oPeriod (hPeriod), .oWidth   (hWidth),
    .oRise   (hRise),   .oFall    (hFall),
    .oArmed  (hArmed),  .oSat     (hSat)
  );

  vga_sync_meter #(.W(11)) uVMeter (
    .clk_vga (clk_vga), .iReset_n (iReset_n),
    .iSync   (rVs),     .iEn      (hRise),
    .oPeriod (vPeriod), .oWidth   (vWidth),
    .oRise   (vRise),   .oFall    (vFall),
    .oArmed  (vArmed),  .oSat     (vSat)
  );

  // position counters; vsync fall wins over a coincident hsync rise
  always_ff @(posedge clk_vga or negedge iReset_n) begin
    if (!iReset_n) begin
      hc <= '0;
      vl <= '0;
    end else begin
      if (hFall)
        hc <= '0;
      else if (hc != HC_MAX)
        hc <= hc + 1'b1;
      if (vFall)
        vl <= '0;
      else if (hRise && (vl != VL_MAX))
        vl <= vl + 1'b1;
    end
  end

  // Checks only count once a rise has been seen; the partial interval
  // between reset and the first edge is meaningless.
  always_comb begin
    errNow              = 4'h0;
    errNow[ERR_HPERIOD] = (hArmed & hRise & (hPeriod != HTOT)) | hSat | (hc == HC_MAX);
    errNow[ERR_HWIDTH]  = hArmed & hFall & (hWidth != HSYNCW);
    errNow[ERR_VPERIOD] = (vArmed & vRise & (vPeriod != VTOT)) | vSat | (vl == VL_MAX);
    errNow[ERR_VWIDTH]  = vArmed & vFall & (vWidth != VSYNCW);
  end
  assign anyErr = |errNow;

  assign xPos     = hc - HB;
  assign yPos     = vl - VB;
  assign pixValid = (hc >= HB) && (hc < HEND) && (vl >= VB) && (vl < VEND);
  assign probeHit = pixValid && (xPos == {1'b0, rProbeX}) && (yPos == rProbeY)
                 && ({1'b0, rProbeX} < HDISP) && (rProbeY < VDISP);
  assign frameUpd = (state == LOCKED) && vRise && !anyErr;

  // state register
  always_ff @(posedge clk_vga or negedge iReset_n) begin
    if (!iReset_n)
      state <= SEARCH;
    else
      state <= nextState;
  end

  // next state; in SEARCH the vsync edge wins over a same-cycle mismatch
  always_comb begin
    nextState = state;
    case (state)
      SEARCH:  if (vRise) nextState = MEASURE;
      MEASURE: if (anyErr) nextState = SEARCH;
               else if (vRise) nextState = LOCKED;
      LOCKED:  if (anyErr) nextState = SEARCH;
      default: nextState = SEARCH;
    endcase
  end

  // outputs from state
  always_comb begin
    oLocked = (state == LOCKED);
  end

  always_ff @(posedge clk_vga or negedge iReset_n) begin
    if (!iReset_n) begin
      oErr       <= 4'h0;
      oFrameDone <= 1'b0;
      oFrameCnt  <= '0;
      oProbeRGB  <= '0;
    end else begin
      oErr       <= oErr | errNow;
      oFrameDone <= frameUpd;
      if (frameUpd)
        oFrameCnt <= oFrameCnt + 1'b1;
      if (probeHit)
        oProbeRGB <= pixD;
    end
  end

`ifdef VGA_MON_CHECKSUM_EN
  logic [15:0] acc;

  // The accumulator runs in every state so the first locked edge already
  // has a whole frame to report.
  always_ff @(posedge clk_vga or negedge iReset_n) begin
    if (!iReset_n) begin
      acc       <= '0;
      oChecksum <= '0;
    end else begin
      if (vRise)
        acc <= pixValid ? {4'h0, pixD} : 16'h0000;
      else if (pixValid)
        acc <= acc + {4'h0, pixD};
      if (frameUpd)
        oChecksum <= acc;
    end
  end
`else
  assign oChecksum = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_frame_monitor.sv
// tb/tb_vga_frame_monitor.sv - self-checking bench for vga_frame_monitor on a scaled-down raster
module tb_vga_frame_monitor;

  localparam int H_DISP  = 8;
  localparam int H_FRONT = 2;
  localparam int H_SYNC  = 3;
  localparam int H_BACK  = 3;
  localparam int H_TOTAL = 16;
  localparam int V_DISP  = 4;
  localparam int V_SYNC  = 2;
  localparam int V_BACK  = 2;
  localparam int V_TOTAL = 9;
  localparam int BIG     = 1 << 30;

  logic        clk_vga;
  logic        iReset_n;
  logic        iVGA_Hsync, iVGA_Vsync;
  logic [11:0] iVGA_RGB;
  logic [10:0] iProbeX, iProbeY;
  logic        oLocked;
  logic [3:0]  oErr;
  logic        oFrameDone;
  logic [15:0] oFrameCnt;
  logic [15:0] oChecksum;
  logic [11:0] oProbeRGB;

  vga_frame_monitor #(
    .H_DISP(H_DISP), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK), .H_TOTAL(H_TOTAL),
    .V_DISP(V_DISP), .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_TOTAL(V_TOTAL)
  ) dut (
    .clk_vga    (clk_vga),
    .iReset_n   (iReset_n),
    .iVGA_Hsync (iVGA_Hsync),
    .iVGA_Vsync (iVGA_Vsync),
    .iVGA_RGB   (iVGA_RGB),
    .iProbeX    (iProbeX),
    .iProbeY    (iProbeY),
    .oLocked    (oLocked),
    .oErr       (oErr),
    .oFrameDone (oFrameDone),
    .oFrameCnt  (oFrameCnt),
    .oChecksum  (oChecksum),
    .oProbeRGB  (oProbeRGB)
  );

  initial clk_vga = 1'b0;
  always #5 clk_vga = ~clk_vga;

  int nCompared = 0;
  int nMismatch = 0;

  // generator configuration
  int          mode = 0;
  int          sx = 0, sy = 0;
  logic [11:0] sv = 12'h000;
  int          shortLine = -1;
  int          shortHsLine = -1;
  int          vsW = V_SYNC;

  typedef struct packed {
    int          mode;
    int          sx;
    int          sy;
    logic [11:0] sv;
    logic [10:0] px;
    logic [10:0] py;
    logic [15:0] cs;
    logic [11:0] probe;
  } vec_t;

  vec_t vecs [6];
  logic [15:0] expCnt;
  logic [15:0] lastCs;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] csExp(input logic [15:0] v);
`ifdef VGA_MON_CHECKSUM_EN
    return v;
`else
    return v & 16'h0000;
`endif
  endfunction

  function automatic logic [11:0] pixFn(input int x, input int y);
    case (mode)
      0:       return (x == sx && y == sy) ? sv : 12'h000;
      1:       return 12'(16 * x + y + 1);
      default: return 12'hFFF;
    endcase
  endfunction

  // Emits frame cycles with linear index in [skip, stopAt). Each line starts
  // with hsync; vsync changes at line starts. Blanking carries 12'hFFF so a
  // misplaced active window shows up in the checksum.
  task automatic sendSpan(input int skip, input int stopAt);
    int n, len, hw, x, y;
    n = 0;
    for (int l = 0; l < V_TOTAL; l++) begin
      len = (l == shortLine) ? H_TOTAL - 1 : H_TOTAL;
      hw  = (l == shortHsLine) ? H_SYNC - 1 : H_SYNC;
      for (int c = 0; c < len; c++) begin
        if (n >= skip && n < stopAt) begin
          x = c - (H_SYNC + H_BACK);
          y = l - (V_SYNC + V_BACK);
          @(negedge clk_vga);
          iVGA_Hsync = (c < hw);
          iVGA_Vsync = (l < vsW);
          iVGA_RGB   = (x >= 0 && x < H_DISP && y >= 0 && y < V_DISP) ? pixFn(x, y) : 12'hFFF;
        end
        n++;
      end
    end
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, " oLocked"}, 32'(oLocked), 32'd0);
    check({tag, " oErr"}, 32'(oErr), 32'd0);
    check({tag, " oFrameDone"}, 32'(oFrameDone), 32'd0);
    check({tag, " oFrameCnt"}, 32'(oFrameCnt), 32'd0);
    check({tag, " oChecksum"}, 32'(oChecksum), 32'd0);
    check({tag, " oProbeRGB"}, 32'(oProbeRGB), 32'd0);
  endtask

  // Reset, then two clean frame starts; lock must appear exactly 2 cycles
  // after the second vsync rise. Leaves the bench inside frame B at index 3.
  task automatic lockUp();
    @(negedge clk_vga);
    iReset_n = 1'b0;
    iVGA_Hsync = 1'b0; iVGA_Vsync = 1'b0; iVGA_RGB = 12'h000;
    mode = 0; sx = 0; sy = 0; sv = 12'h000;
    shortLine = -1; shortHsLine = -1; vsW = V_SYNC;
    #1;
    checkAllZero("reset");
    repeat (3) @(negedge clk_vga);
    iReset_n = 1'b1;
    repeat (2) @(negedge clk_vga);
    sendSpan(0, 3);
    check("lock after first vsync", 32'(oLocked), 32'd0);
    sendSpan(3, BIG);
    sendSpan(0, 2);
    check("lock one cycle after second vsync", 32'(oLocked), 32'd0);
    sendSpan(2, 3);
    check("lock two cycles after second vsync", 32'(oLocked), 32'd1);
    check("clean stream oErr", 32'(oErr), 32'd0);
    check("lock edge oFrameDone", 32'(oFrameDone), 32'd0);
    check("lock edge oFrameCnt", 32'(oFrameCnt), 32'd0);
    expCnt = 16'd0;
  endtask

  initial begin
    iReset_n = 1'b0;
    iVGA_Hsync = 1'b0; iVGA_Vsync = 1'b0; iVGA_RGB = 12'h000;
    iProbeX = 11'd0; iProbeY = 11'd0;

    //              mode sx sy  sv       px      py      checksum  probe
    vecs[0] = '{0, 0, 0, 12'h123, 11'd7, 11'd3, 16'h0123, 12'h000};
    vecs[1] = '{0, 7, 3, 12'hABC, 11'd7, 11'd3, 16'h0ABC, 12'hABC};
    vecs[2] = '{1, 0, 0, 12'h000, 11'd2, 11'd1, 16'h0750, 12'h022};
    vecs[3] = '{0, 3, 2, 12'h5A5, 11'd8, 11'd0, 16'h05A5, 12'h022};
    vecs[4] = '{0, 0, 0, 12'h000, 11'd0, 11'd4, 16'h0000, 12'h022};
    vecs[5] = '{2, 0, 0, 12'h000, 11'd0, 11'd0, 16'hFFE0, 12'hFFF};

    lockUp();

    // frame summaries: each record's frame is checked at the next vsync rise
    for (int i = 0; i < 6; i++) begin
      mode = vecs[i].mode; sx = vecs[i].sx; sy = vecs[i].sy; sv = vecs[i].sv;
      iProbeX = vecs[i].px; iProbeY = vecs[i].py;
      sendSpan(3, BIG);
      sendSpan(0, 2);
      check($sformatf("vec%0d oFrameDone early", i), 32'(oFrameDone), 32'd0);
      sendSpan(2, 3);
      expCnt = expCnt + 16'd1;
      check($sformatf("vec%0d oFrameDone", i), 32'(oFrameDone), 32'd1);
      check($sformatf("vec%0d oFrameCnt", i), 32'(oFrameCnt), 32'(expCnt));
      check($sformatf("vec%0d oChecksum", i), 32'(oChecksum), 32'(csExp(vecs[i].cs)));
      check($sformatf("vec%0d oProbeRGB", i), 32'(oProbeRGB), 32'(vecs[i].probe));
      check($sformatf("vec%0d oLocked", i), 32'(oLocked), 32'd1);
      check($sformatf("vec%0d oErr", i), 32'(oErr), 32'd0);
    end
    lastCs = csExp(vecs[5].cs);

    // one line a clock short: the hsync rise at index 79 reports it
    mode = 0; sv = 12'h000;
    shortLine = 4;
    sendSpan(3, 80);
    sendSpan(80, 81);
    check("short line oErr one cycle after", 32'(oErr), 32'd0);
    check("short line oLocked one cycle after", 32'(oLocked), 32'd1);
    sendSpan(81, 82);
    check("short line oErr", 32'(oErr), 32'b0001);
    check("short line oLocked", 32'(oLocked), 32'd0);
    sendSpan(82, BIG);
    shortLine = -1;
    sendSpan(0, 3);
    check("relock after first clean vsync", 32'(oLocked), 32'd0);
    check("no count while unlocked", 32'(oFrameCnt), 32'(expCnt));
    sendSpan(3, BIG);
    sendSpan(0, 3);
    check("relock after second clean vsync", 32'(oLocked), 32'd1);
    check("oErr sticky after relock", 32'(oErr), 32'b0001);
    check("oFrameCnt held through unlock", 32'(oFrameCnt), 32'(expCnt));
    check("oChecksum held through unlock", 32'(oChecksum), 32'(lastCs));

    // asynchronous reset in the middle of a frame
    sendSpan(3, 50);
    #3;
    iReset_n = 1'b0;
    #1;
    checkAllZero("mid-frame reset");

    // hsync pulse one clock short
    lockUp();
    shortHsLine = 3;
    sendSpan(3, BIG);
    shortHsLine = -1;
    sendSpan(0, 3);
    check("short hsync oErr", 32'(oErr), 32'b0010);
    check("short hsync oLocked", 32'(oLocked), 32'd0);
    check("short hsync oFrameCnt", 32'(oFrameCnt), 32'd0);

    // vsync pulse one line short
    lockUp();
    vsW = V_SYNC - 1;
    sendSpan(3, BIG);
    vsW = V_SYNC;
    sendSpan(0, 3);
    check("short vsync oErr", 32'(oErr), 32'b1000);
    check("short vsync oLocked", 32'(oLocked), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
